edp_mul_div_seq: RTL
====================

Name: edp_mul_div_seq

Overview:
- Step sequencer for the EDP multiply and divide loops.
- Once started, it takes over the per-cycle AD function, shift direction and register-load controls of the AR/ARX/MQ slices.
- Multiply: radix-4 Booth, 2 bits per step. Divide: non-restoring, 1 quotient bit per step.
- Sits beside CTL: CTL muxes these outputs onto the slice select lines while busy_h is asserted.

Parameters:
- MUL_STEPS, 18, Booth steps per multiply (36 bits / 2).
- DIV_STEPS, 36, quotient steps per divide.
- CTR_W, 6, step counter width; must satisfy 2**CTR_W > max(MUL_STEPS, DIV_STEPS).

Ports:
- clk_edp_h  input  1  EDP clock; all state changes on the rising edge.
- mr_reset_l  input  1  asynchronous active-low master reset.
- start_mul_h  input  1  begin multiply; sampled only in IDLE.
- start_div_h  input  1  begin divide; sampled only in IDLE.
- abort_h  input  1  page-fail/interrupt kill; returns to IDLE.
- mq_34_h  input  1  MQ bit 34 (Booth pair, high bit).
- mq_35_h  input  1  MQ bit 35 (Booth pair, low bit).
- ad_00_h  input  1  AD sign bit, current-cycle result.
- busy_h  output  1  sequencer owns the EDP controls.
- done_h  output  1  one-cycle completion pulse.
- div_ovf_h  output  1  divide overflow; held until next start.
- ad_func  output  3  AD operation code (package enum).
- shift_dir  output  2  AR/ARX/MQ shift (package enum).
- load_h  output  1  load strobe for AR, ARX and MQ.
- q_bit_h  output  1  quotient bit shifted into MQ35.
- step_ctr  output  CTR_W  remaining steps (diagnostic read).

Behaviour:
- Reset (async, mr_reset_l=0): state IDLE; step_ctr=0; prev_bit=0.
  - All outputs 0: ad_func=AD_PASS, shift_dir=SH_NONE.
  - Reset deasserted mid-operation is not resumed; the sequencer stays in IDLE.
- States: IDLE, MUL_STEP, DIV_FIRST, DIV_STEP, DIV_FIX, DONE.
- IDLE:
  - start_mul_h=1 -> MUL_STEP; step_ctr=MUL_STEPS; prev_bit=0.
  - else start_div_h=1 -> DIV_FIRST. Simultaneous starts: multiply wins.
  - Starts while not in IDLE are ignored.
- busy_h=1 in every state except IDLE, including DONE.
- MUL_STEP:
  - ad_func is combinational from {mq_34_h, mq_35_h, prev_bit}:
    - 000 or 111 -> PASS
    - 001 or 010 -> ADD
    - 011 -> ADD2
    - 100 -> SUB2
    - 101 or 110 -> SUB
  - shift_dir=SH_R2; load_h=1.
  - Each edge: prev_bit<=mq_34_h; step_ctr decrements.
  - Leaving at step_ctr==1 -> DONE. A multiply therefore spends exactly MUL_STEPS cycles in MUL_STEP.
- DIV_FIRST (1 cycle):
  - ad_func=SUB; load_h=0 (trial only).
  - ad_00_h=0 (high dividend >= divisor) -> div_ovf_h<=1 and go to DONE.
  - else -> DIV_STEP; step_ctr=DIV_STEPS.
- DIV_STEP:
  - ad_func=SUB if sign_reg=0, else ADD. sign_reg is loaded with ad_00_h at each step and holds 1 on entry from DIV_FIRST.
  - shift_dir=SH_L1; load_h=1; q_bit_h=~ad_00_h.
  - step_ctr decrements; leaving at step_ctr==1 -> DIV_FIX.
- DIV_FIX (1 cycle):
  - If sign_reg=1: ad_func=ADD, shift_dir=SH_NONE, load_h=1 (remainder correction).
  - Else: PASS, load_h=0.
  - -> DONE.
- DONE: done_h=1 for exactly one cycle -> IDLE.
- Latency from start edge to the done_h cycle:
  - multiply: MUL_STEPS+1
  - divide: DIV_STEPS+3
  - overflow: 2
- abort_h=1 in any non-IDLE state:
  - Next state is IDLE; no done_h; div_ovf_h unchanged.
  - Controls forced to PASS/NONE/load 0 combinationally in that cycle.
  - abort_h has priority over every other transition.
- div_ovf_h clears on an accepted start.
- step_ctr never wraps: it is 0 in IDLE and DONE, and never decrements below 1 inside a step state.

Decomposition:
- Package edp_seq_pkg holds:
  - ad_func_t enum: AD_PASS=0, AD_ADD=1, AD_SUB=2, AD_ADD2=3, AD_SUB2=4.
  - shift_t enum: SH_NONE=0, SH_R2=1, SH_L1=2.
  - seq_state_t.
  - The Booth decode function.
- One sub-module is natural: edp_booth_dec, a pure combinational 3-bit -> ad_func_t decoder. It is reused by the diagnostic model.

Test Plan:
- Multiply, MQ pair stream all 01, prev 0:
  - Step 1 ad_func=ADD, later steps ADD (011 -> ADD2 only when mq_34=0, mq_35=1, prev=1; check the full table via 8 forced patterns).
  - done_h in cycle 19; busy_h high for cycles 1-19.
- Divide, ad_00_h driven 1 in DIV_FIRST, then alternating 0/1:
  - ad_func alternates SUB/ADD per sign_reg.
  - q_bit_h = ~ad_00_h on each step.
  - DIV_FIX performs ADD when last sign=1.
  - done_h in cycle 39.
- Divide overflow, ad_00_h=0 in DIV_FIRST:
  - div_ovf_h=1; done_h at cycle 2; no load_h ever asserted.
  - div_ovf_h clears on the next start_mul_h.
- abort_h pulsed at MUL_STEP cycle 7:
  - IDLE next cycle; no done_h; step_ctr=0.
  - A start_div_h issued while busy, before the abort, is ignored.
- mr_reset_l pulsed low mid-divide, asynchronously between edges:
  - All outputs zero immediately.
  - Stays IDLE after release until a new start.
- start_mul_h and start_div_h together -> multiply sequence runs.

Source files
------------

// File: rtl/edp_seq_pkg.sv
// edp_seq_pkg: shared encodings and Booth decode for the EDP multiply/divide sequencer.
package edp_seq_pkg;

    typedef enum logic [2:0] {
        AD_PASS = 3'd0,
        AD_ADD  = 3'd1,
        AD_SUB  = 3'd2,
        AD_ADD2 = 3'd3,
        AD_SUB2 = 3'd4
    } ad_func_t;

    typedef enum logic [1:0] {
        SH_NONE = 2'd0,
        SH_R2   = 2'd1,
        SH_L1   = 2'd2
    } shift_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        MUL_STEP  = 3'd1,
        DIV_FIRST = 3'd2,
        DIV_STEP  = 3'd3,
        DIV_FIX   = 3'd4,
        DONE      = 3'd5
    } seq_state_t;

    // pat = {mq_34, mq_35, prev_bit}
    function automatic ad_func_t booth_dec(input logic [2:0] pat);
        case (pat)
            3'b001, 3'b010: return AD_ADD;
            3'b011:         return AD_ADD2;
            3'b100:         return AD_SUB2;
            3'b101, 3'b110: return AD_SUB;
            default:        return AD_PASS;
        endcase
    endfunction

endpackage

// File: rtl/edp_booth_dec.sv
// edp_booth_dec: radix-4 Booth pair decoder, {mq_34, mq_35, prev_bit} to AD function.
module edp_booth_dec
    import edp_seq_pkg::*;
(
    input  logic [2:0] pat,
    output ad_func_t   func
);

    assign func = booth_dec(pat);

endmodule

// File: rtl/edp_mul_div_seq.sv
// edp_mul_div_seq: step sequencer driving AD/shift/load controls for EDP multiply and divide.
module edp_mul_div_seq
    import edp_seq_pkg::*;
#(
    parameter int MUL_STEPS = 18,
    parameter int DIV_STEPS = 36,
    parameter int CTR_W     = 6
) (
    input  logic             clk_edp_h,
    input  logic             mr_reset_l,
    input  logic             start_mul_h,
    input  logic             start_div_h,
    input  logic             abort_h,
    input  logic             mq_34_h,
    input  logic             mq_35_h,
    input  logic             ad_00_h,
    output logic             busy_h,
    output logic             done_h,
    output logic             div_ovf_h,
    output ad_func_t         ad_func,
    output shift_t           shift_dir,
    output logic             load_h,
    output logic             q_bit_h,
    output logic [CTR_W-1:0] step_ctr
);

    seq_state_t       state, state_nx;
    logic [CTR_W-1:0] ctr_nx;
    logic             prev_bit, prev_nx, sign_reg, sign_nx, ovf_nx;
    ad_func_t         booth_func;

    edp_booth_dec u_booth_dec (
        .pat  ({mq_34_h, mq_35_h, prev_bit}),
        .func (booth_func)
    );

    always_ff @(posedge clk_edp_h or negedge mr_reset_l) begin
        if (!mr_reset_l) begin
            state     <= IDLE;
            step_ctr  <= '0;
            prev_bit  <= 1'b0;
            sign_reg  <= 1'b0;
            div_ovf_h <= 1'b0;
        end else begin
            state     <= state_nx;
            step_ctr  <= ctr_nx;
            prev_bit  <= prev_nx;
            sign_reg  <= sign_nx;
            div_ovf_h <= ovf_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        ctr_nx    = step_ctr;
        prev_nx   = prev_bit;
        sign_nx   = sign_reg;
        ovf_nx    = div_ovf_h;
        busy_h    = state != IDLE;
        done_h    = 1'b0;
        ad_func   = AD_PASS;
        shift_dir = SH_NONE;
        load_h    = 1'b0;
        q_bit_h   = 1'b0;
        case (state)
            IDLE: begin
                if (start_mul_h) begin
                    state_nx = MUL_STEP;
                    ctr_nx   = CTR_W'(MUL_STEPS);
                    prev_nx  = 1'b0;
                    ovf_nx   = 1'b0;
                end else if (start_div_h) begin
                    state_nx = DIV_FIRST;
                    ovf_nx   = 1'b0;
                end
            end
            MUL_STEP: begin
                ad_func   = booth_func;
                shift_dir = SH_R2;
                load_h    = 1'b1;
                prev_nx   = mq_34_h;
                ctr_nx    = step_ctr - CTR_W'(1);
                state_nx  = (step_ctr == CTR_W'(1)) ? DONE : MUL_STEP;
            end
            DIV_FIRST: begin
                // trial subtract only: a non-negative result means the quotient cannot fit
                ad_func  = AD_SUB;
                state_nx = ad_00_h ? DIV_STEP : DONE;
                ovf_nx   = ~ad_00_h;
                ctr_nx   = ad_00_h ? CTR_W'(DIV_STEPS) : '0;
                sign_nx  = 1'b1;
            end
            DIV_STEP: begin
                ad_func   = sign_reg ? AD_ADD : AD_SUB;
                shift_dir = SH_L1;
                load_h    = 1'b1;
                q_bit_h   = ~ad_00_h;
                sign_nx   = ad_00_h;
                ctr_nx    = step_ctr - CTR_W'(1);
                state_nx  = (step_ctr == CTR_W'(1)) ? DIV_FIX : DIV_STEP;
            end
            DIV_FIX: begin
                ad_func  = sign_reg ? AD_ADD : AD_PASS;
                load_h   = sign_reg;
                state_nx = DONE;
            end
            DONE: begin
                done_h   = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (abort_h && state != IDLE) begin
            state_nx  = IDLE;
            ctr_nx    = '0;
            ovf_nx    = div_ovf_h;
            done_h    = 1'b0;
            ad_func   = AD_PASS;
            shift_dir = SH_NONE;
            load_h    = 1'b0;
            q_bit_h   = 1'b0;
        end
    end

endmodule
